bus_sequencer: RTL and testbench
================================

# bus_sequencer

Parametrised, multi-cycle external bus sequencer that replaces the single-phase strobe logic in the CPU's bus interface. It accepts one request at a time from the CPU/debug address and data muxes. It then runs a SETUP / STROBE / HOLD bus cycle on the pin buffers with programmable wait states, an external READY handshake and byte-lane steering, and returns read data with a completion pulse. It sits between the address/data muxes and the pin buffers.

## Interface
- DATA_W, 16, data bus width; multiple of 8; DATA_W/8 (LANES) a power of two.
- ADDR_W, 16, address width.
- WAIT_STATES, 0, minimum extra STROBE cycles, range 0..15.
- TIMEOUT_CYCLES, 64, maximum STROBE cycles before abort; used only with BUS_TIMEOUT_EN.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  1  request strobe; sampled only while REQ_RDY=1.
- REQ_WR  in  1  1 = write, 0 = read.
- REQ_BYTE  in  1  1 = byte access, 0 = full-word access.
- REQ_ADDR  in  ADDR_W  access address.
- REQ_WDATA  in  DATA_W  write data; for byte accesses the byte is in bits [7:0].
- REQ_RDY  out  1  sequencer can accept REQ this cycle.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  valid with DONE; 1 = timed out.
- RDATA  out  DATA_W  read result; held until the next read's DONE.
- ADDR_BUF  out  ADDR_W  pin address.
- DOUT_BUF  out  DATA_W  pin write data.
- DIN_BUF  in  DATA_W  pin read data.
- READY_BUF  in  1  external ready; 0 extends STROBE.
- RD_BUF  out  1  read strobe.
- WR_BUF  out  LANES  per-lane write strobes; bit n covers data bits [8n+7:8n].

## Operation
- States: IDLE, SETUP, STROBE, HOLD. REQ_RDY=1 in IDLE and HOLD only.
- **IDLE/HOLD + REQ=1:** capture REQ_WR, REQ_BYTE, REQ_ADDR and REQ_WDATA, then go to SETUP. Otherwise HOLD goes to IDLE.
- **SETUP** (exactly 1 cycle): ADDR_BUF and DOUT_BUF are driven from the captured request; strobes are 0. Load the wait counter with WAIT_STATES and the timeout counter with TIMEOUT_CYCLES-1. Go to STROBE.
- **STROBE:**
  - Read: RD_BUF=1. Write: WR_BUF = lane mask.
  - Wait counter decrements to 0.
  - Exit when wait counter==0 and READY_BUF=1: latch read data, go to HOLD.
- **HOLD** (1 cycle): strobes 0; ADDR_BUF and DOUT_BUF held; DONE=1.
- **Lane select** = REQ_ADDR[log2(LANES)-1:0].
  - Word access: mask all ones; DOUT_BUF = REQ_WDATA; RDATA = DIN_BUF.
  - Byte access: mask is one-hot at the lane; DOUT_BUF = REQ_WDATA[7:0] shifted to the lane with other bits 0; RDATA = selected DIN_BUF byte, zero-extended.
- Word accesses to unaligned addresses drive all lanes; the low address bits pass through unchanged.
- Writes leave RDATA unchanged. ERR=0 on normal completion.

## Timing
- **Reset values:** state IDLE, REQ_RDY=1, DONE=0, ERR=0, RDATA=0, ADDR_BUF=0, DOUT_BUF=0, RD_BUF=0, WR_BUF=0, all counters 0.
- **Latency:** REQ sampled at edge 0 → SETUP in cycle 1 → STROBE in cycles 2..2+WAIT_STATES (longer while READY_BUF=0) → HOLD/DONE one cycle later.
  - Minimum: DONE in cycle 3 after the REQ edge.
  - Back-to-back: REQ in HOLD gives a 3-cycle throughput per access.
- Strobes are never high in SETUP or HOLD. Address and data are stable for one full cycle either side of any strobe.
- READY_BUF is sampled only in STROBE, and only once the wait counter reaches 0.
- RESET=1 at any edge aborts the cycle. Outputs take their reset values at that edge, strobes drop immediately and the captured request is discarded; no DONE is issued.
- REQ while REQ_RDY=0 is ignored and not queued.

## Configuration
- **BUS_TIMEOUT_EN defined:**
  - The timeout counter decrements each STROBE cycle.
  - If it reaches 0 before the exit condition, go to HOLD with DONE=1 and ERR=1. Strobes drop.
  - On a timed-out read, RDATA is all ones.
- **BUS_TIMEOUT_EN undefined:** STROBE waits indefinitely for READY_BUF; ERR is tied 0; no timeout counter is present.

## Test plan
- **Word read:** DATA_W=16, WAIT_STATES=0, READY_BUF=1, read 0x1234 with DIN_BUF=0xBEEF → RD_BUF high only in cycle 2; DONE in cycle 3; RDATA=0xBEEF; ERR=0.
- **Byte write, high lane:** write to 0x0011, REQ_WDATA=0x00A5 → WR_BUF=2'b10 for one cycle; DOUT_BUF=0xA500. Same write to 0x0010 → WR_BUF=2'b01, DOUT_BUF=0x00A5.
- **Wait states and READY:** WAIT_STATES=2, READY_BUF held low 3 extra cycles → RD_BUF high for 6 cycles; DONE 7 cycles after SETUP. Byte read at an odd address with DIN_BUF=0xC300 → RDATA=0x00C3.
- **Back-to-back:** REQ asserted in HOLD → next SETUP on the following cycle with no IDLE cycle; two DONE pulses 3 cycles apart.
- **Timeout:** BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, READY_BUF stuck 0 → DONE and ERR high 8 STROBE cycles later; RDATA=0xFFFF. Macro undefined → no DONE after 100 cycles.
- **Reset mid-cycle:** RESET during STROBE of a write → at the next edge WR_BUF=0, REQ_RDY=1, no DONE; the next request completes normally.

Source files
------------

// File: rtl/bus_sequencer_if.sv
// Bus sequencer interface: CPU-side request/response handshake plus the
// pin-buffer side of the external bus.
// The master modport is the request source and the pin inputs.
// The slave modport is the sequencer itself.
interface bus_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  REQ;
  logic                  REQ_WR;
  logic                  REQ_BYTE;
  logic [ADDR_W-1:0]     REQ_ADDR;
  logic [DATA_W-1:0]     REQ_WDATA;
  logic                  REQ_RDY;
  logic                  DONE;
  logic                  ERR;
  logic [DATA_W-1:0]     RDATA;
  logic [ADDR_W-1:0]     ADDR_BUF;
  logic [DATA_W-1:0]     DOUT_BUF;
  logic [DATA_W-1:0]     DIN_BUF;
  logic                  READY_BUF;
  logic                  RD_BUF;
  logic [DATA_W/8-1:0]   WR_BUF;

  modport master (
    output REQ, REQ_WR, REQ_BYTE, REQ_ADDR, REQ_WDATA, DIN_BUF, READY_BUF,
    input  REQ_RDY, DONE, ERR, RDATA, ADDR_BUF, DOUT_BUF, RD_BUF, WR_BUF
  );

  modport slave (
    input  REQ, REQ_WR, REQ_BYTE, REQ_ADDR, REQ_WDATA, DIN_BUF, READY_BUF,
    output REQ_RDY, DONE, ERR, RDATA, ADDR_BUF, DOUT_BUF, RD_BUF, WR_BUF
  );
endinterface

// File: rtl/bus_sequencer.sv
// bus_sequencer: runs one SETUP / STROBE / HOLD external bus cycle per
// request, with programmable wait states, READY extension and byte-lane
// steering.
// Optional feature macro: BUS_TIMEOUT_EN. When it is defined, a STROBE
// that lasts TIMEOUT_CYCLES cycles is aborted with ERR=1. When it is
// undefined, STROBE waits for READY_BUF forever and ERR is tied low.
module bus_sequencer #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int WAIT_STATES    = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic           CLK,
  input  logic           RESET,
  bus_sequencer_if.slave bus
);
  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t state_reg, state_next;

  // Captured request; byte steering is applied once, at capture time.
  logic                wr_reg;
  logic                byte_reg;
  logic [LANE_W-1:0]   lane_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   dout_reg;
  logic [LANES-1:0]    mask_reg;

  logic [3:0]          wait_reg, wait_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                rd_buf_reg;
  logic [LANES-1:0]    wr_buf_reg;
  logic                done_reg;
  logic                capture;
  logic                timeout;

  // Lane steering of the incoming request and of the returning pin data.
  logic [LANE_W-1:0]           req_lane;
  logic [LANES-1:0]            req_mask;
  logic [DATA_W-1:0]           req_dout;
  logic [LANES-1:0][7:0]       din_lanes;
  logic [7:0]                  rd_byte;
  logic [DATA_W-1:0]           rd_word;

  generate
    if (LANES > 1) begin : g_lane_sel
      assign req_lane = bus.REQ_ADDR[LANE_W-1:0];
    end else begin : g_single_lane
      assign req_lane = '0;
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign req_mask[gi] = !bus.REQ_BYTE || (req_lane == LANE_W'(gi));
      assign req_dout[8*gi +: 8] = !bus.REQ_BYTE ? bus.REQ_WDATA[8*gi +: 8] :
                                   (req_lane == LANE_W'(gi)) ? bus.REQ_WDATA[7:0] : 8'h00;
      assign din_lanes[gi] = bus.DIN_BUF[8*gi +: 8];
    end
  endgenerate

  assign rd_byte = din_lanes[lane_reg];
  assign rd_word = byte_reg ? DATA_W'(rd_byte) : bus.DIN_BUF;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_reg, to_next;
  logic            err_reg;
`endif

  // Next-state, counter and read-data decisions for the bus cycle.
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    rdata_next = rdata_reg;
    capture    = 1'b0;
    timeout    = 1'b0;
`ifdef BUS_TIMEOUT_EN
    to_next    = to_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (bus.REQ) begin
          capture    = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        wait_next  = 4'(WAIT_STATES);
`ifdef BUS_TIMEOUT_EN
        to_next    = TO_W'(TIMEOUT_CYCLES - 1);
`endif
        state_next = STROBE;
      end
      STROBE: begin
        if (wait_reg != 4'd0) begin
          wait_next = wait_reg - 4'd1;
        end
        // READY_BUF only matters once the minimum wait has elapsed.
        if ((wait_reg == 4'd0) && bus.READY_BUF) begin
          state_next = HOLD;
          if (!wr_reg) begin
            rdata_next = rd_word;
          end
        end
`ifdef BUS_TIMEOUT_EN
        else if (to_reg == '0) begin
          state_next = HOLD;
          timeout    = 1'b1;
          if (!wr_reg) begin
            rdata_next = '1;
          end
        end else begin
          to_next = to_reg - TO_W'(1);
        end
`endif
      end
      HOLD: begin
        // Back-to-back: a request taken here skips IDLE entirely.
        if (bus.REQ) begin
          capture    = 1'b1;
          state_next = SETUP;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, captured request and registered pin strobes / completion.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      wr_reg     <= 1'b0;
      byte_reg   <= 1'b0;
      lane_reg   <= '0;
      addr_reg   <= '0;
      dout_reg   <= '0;
      mask_reg   <= '0;
      wait_reg   <= 4'd0;
      rdata_reg  <= '0;
      rd_buf_reg <= 1'b0;
      wr_buf_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wait_reg   <= wait_next;
      rdata_reg  <= rdata_next;
      if (capture) begin
        wr_reg   <= bus.REQ_WR;
        byte_reg <= bus.REQ_BYTE;
        lane_reg <= req_lane;
        addr_reg <= bus.REQ_ADDR;
        dout_reg <= req_dout;
        mask_reg <= req_mask;
      end
      // Strobes are registered from the next state so the pins never glitch.
      rd_buf_reg <= (state_next == STROBE) && !wr_reg;
      wr_buf_reg <= ((state_next == STROBE) && wr_reg) ? mask_reg : '0;
      done_reg   <= (state_next == HOLD);
    end
  end

`ifdef BUS_TIMEOUT_EN
  // Timeout counter and the error flag that accompanies DONE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      to_reg  <= '0;
      err_reg <= 1'b0;
    end else begin
      to_reg  <= to_next;
      err_reg <= timeout;
    end
  end
  assign bus.ERR = err_reg;
`else
  assign bus.ERR = timeout;
`endif

  assign bus.REQ_RDY  = (state_reg == IDLE) || (state_reg == HOLD);
  assign bus.DONE     = done_reg;
  assign bus.RDATA    = rdata_reg;
  assign bus.ADDR_BUF = addr_reg;
  assign bus.DOUT_BUF = dout_reg;
  assign bus.RD_BUF   = rd_buf_reg;
  assign bus.WR_BUF   = wr_buf_reg;
endmodule

// File: tb/tb_bus_sequencer.sv
// Testbench for bus_sequencer: table-driven single accesses on a
// zero-wait-state instance, plus hand-written wait-state, back-to-back,
// timeout/stall and reset-abort sequences.
module tb_bus_sequencer;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 CLK = ~CLK;

  bus_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bi0 ();
  bus_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bi2 ();

  bus_sequencer #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(0), .TIMEOUT_CYCLES(8))
    dut0 (.CLK(CLK), .RESET(RESET), .bus(bi0.slave));
  bus_sequencer #(.DATA_W(16), .ADDR_W(16), .WAIT_STATES(2), .TIMEOUT_CYCLES(8))
    dut2 (.CLK(CLK), .RESET(RESET), .bus(bi2.slave));

  typedef struct {
    logic        wr;
    logic        is_byte;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] din;
    logic [15:0] exp_rdata;
    logic [15:0] exp_dout;
    logic [1:0]  exp_wrb;
  } vec_t;

  localparam int NV = 8;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt;
    int done_c;
    int done_n;
    int addr_bad;

    //        wr    byte  addr      wdata     din       rdata     dout      wrb
    vec[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0000, 2'b00};
    vec[1] = '{1'b1, 1'b1, 16'h0011, 16'h00A5, 16'h0000, 16'hBEEF, 16'hA500, 2'b10};
    vec[2] = '{1'b1, 1'b1, 16'h0010, 16'h00A5, 16'h0000, 16'hBEEF, 16'h00A5, 2'b01};
    vec[3] = '{1'b0, 1'b1, 16'h0021, 16'h0000, 16'hC300, 16'h00C3, 16'h0000, 2'b00};
    vec[4] = '{1'b0, 1'b1, 16'h0020, 16'h0000, 16'hC35A, 16'h005A, 16'h0000, 2'b00};
    vec[5] = '{1'b1, 1'b0, 16'h0033, 16'h1357, 16'h0000, 16'h005A, 16'h1357, 2'b11};
    vec[6] = '{1'b0, 1'b0, 16'h0035, 16'h0000, 16'h8001, 16'h8001, 16'h0000, 2'b00};
    vec[7] = '{1'b1, 1'b1, 16'h0040, 16'hFFA5, 16'h0000, 16'h8001, 16'h00A5, 2'b01};

    bi0.REQ = 0; bi0.REQ_WR = 0; bi0.REQ_BYTE = 0; bi0.REQ_ADDR = 0;
    bi0.REQ_WDATA = 0; bi0.DIN_BUF = 0; bi0.READY_BUF = 1;
    bi2.REQ = 0; bi2.REQ_WR = 0; bi2.REQ_BYTE = 0; bi2.REQ_ADDR = 0;
    bi2.REQ_WDATA = 0; bi2.DIN_BUF = 0; bi2.READY_BUF = 1;

    // Reset state
    RESET = 1;
    tick(); tick();
    chk("rst_rdy",   bi0.REQ_RDY, 1);
    chk("rst_done",  bi0.DONE, 0);
    chk("rst_err",   bi0.ERR, 0);
    chk("rst_rdata", bi0.RDATA, 0);
    chk("rst_addr",  bi0.ADDR_BUF, 0);
    chk("rst_dout",  bi0.DOUT_BUF, 0);
    chk("rst_strb",  {bi0.RD_BUF, bi0.WR_BUF}, 0);
    chk("rst2_rdy",  bi2.REQ_RDY, 1);
    chk("rst2_strb", {bi2.RD_BUF, bi2.WR_BUF, bi2.DONE}, 0);
    RESET = 0;
    tick();
    $display("reset: rdy=%0d done=%0d rdata=%h", bi0.REQ_RDY, bi0.DONE, bi0.RDATA);

    // Table-driven single accesses, zero wait states, READY high
    for (int i = 0; i < NV; i++) begin
      bi0.REQ = 1; bi0.REQ_WR = vec[i].wr; bi0.REQ_BYTE = vec[i].is_byte;
      bi0.REQ_ADDR = vec[i].addr; bi0.REQ_WDATA = vec[i].wdata;
      bi0.DIN_BUF = vec[i].din; bi0.READY_BUF = 1;
      tick();
      bi0.REQ = 0;
      // cycle 1: SETUP
      chk("setup_rdy",  bi0.REQ_RDY, 0);
      chk("setup_addr", bi0.ADDR_BUF, vec[i].addr);
      chk("setup_dout", bi0.DOUT_BUF, vec[i].exp_dout);
      chk("setup_strb", {bi0.RD_BUF, bi0.WR_BUF}, 0);
      tick();
      // cycle 2: STROBE
      chk("strobe_rd",   bi0.RD_BUF, !vec[i].wr);
      chk("strobe_wr",   bi0.WR_BUF, vec[i].exp_wrb);
      chk("strobe_done", bi0.DONE, 0);
      chk("strobe_addr", bi0.ADDR_BUF, vec[i].addr);
      tick();
      // cycle 3: HOLD
      chk("hold_done",  bi0.DONE, 1);
      chk("hold_err",   bi0.ERR, 0);
      chk("hold_rdata", bi0.RDATA, vec[i].exp_rdata);
      chk("hold_strb",  {bi0.RD_BUF, bi0.WR_BUF}, 0);
      chk("hold_addr",  bi0.ADDR_BUF, vec[i].addr);
      chk("hold_dout",  bi0.DOUT_BUF, vec[i].exp_dout);
      chk("hold_rdy",   bi0.REQ_RDY, 1);
      tick();
      // cycle 4: IDLE
      chk("idle_done", bi0.DONE, 0);
      chk("idle_rdy",  bi0.REQ_RDY, 1);
      $display("vec %0d: wr=%0d byte=%0d addr=%h dout=%h rdata=%h", i, vec[i].wr,
               vec[i].is_byte, vec[i].addr, bi0.DOUT_BUF, bi0.RDATA);
    end

    // Back-to-back: second request presented during HOLD
    bi0.REQ = 1; bi0.REQ_WR = 0; bi0.REQ_BYTE = 0; bi0.REQ_ADDR = 16'h0050;
    bi0.DIN_BUF = 16'h1111;
    tick(); bi0.REQ = 0;
    tick();
    tick();
    chk("b2b_done1",  bi0.DONE, 1);
    chk("b2b_rdata1", bi0.RDATA, 16'h1111);
    bi0.REQ = 1; bi0.REQ_WR = 1; bi0.REQ_ADDR = 16'h0060; bi0.REQ_WDATA = 16'h2222;
    tick(); bi0.REQ = 0;
    chk("b2b_setup_rdy",  bi0.REQ_RDY, 0);
    chk("b2b_setup_addr", bi0.ADDR_BUF, 16'h0060);
    chk("b2b_setup_done", bi0.DONE, 0);
    tick();
    chk("b2b_strobe_wr", bi0.WR_BUF, 2'b11);
    chk("b2b_strobe_done", bi0.DONE, 0);
    tick();
    chk("b2b_done2",  bi0.DONE, 1);
    chk("b2b_rdata2", bi0.RDATA, 16'h1111);
    tick();
    $display("back-to-back: second write done, rdata=%h", bi0.RDATA);

    // Wait states: WS=2, READY low for the first 3 cycles after the wait count
    bi2.REQ = 1; bi2.REQ_WR = 0; bi2.REQ_BYTE = 1; bi2.REQ_ADDR = 16'h0101;
    bi2.DIN_BUF = 16'hC300; bi2.READY_BUF = 0;
    tick(); bi2.REQ = 0;
    rd_cnt = 0; done_c = 0; done_n = 0; addr_bad = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bi2.RD_BUF) rd_cnt++;
      if (bi2.DONE) begin
        done_n++;
        if (done_c == 0) done_c = c;
      end
      if (c <= 8 && bi2.ADDR_BUF !== 16'h0101) addr_bad++;
      // Ignored request while busy
      if (c == 3) begin bi2.REQ = 1; bi2.REQ_ADDR = 16'h0202; end
      if (c == 4) bi2.REQ = 0;
      if (c == 7) bi2.READY_BUF = 1;
      tick();
    end
    chk("ws_rd_cycles", rd_cnt, 6);
    chk("ws_done_cycle", done_c, 8);
    chk("ws_done_count", done_n, 1);
    chk("ws_addr_stable", addr_bad, 0);
    chk("ws_rdata", bi2.RDATA, 16'h00C3);
    chk("ws_rdy", bi2.REQ_RDY, 1);
    $display("wait states: rd cycles=%0d done cycle=%0d rdata=%h", rd_cnt, done_c, bi2.RDATA);

    // Wait states with READY already high: READY ignored until count is 0
    bi2.REQ = 1; bi2.REQ_WR = 0; bi2.REQ_BYTE = 0; bi2.REQ_ADDR = 16'h0104;
    bi2.DIN_BUF = 16'h4242; bi2.READY_BUF = 1;
    tick(); bi2.REQ = 0;
    rd_cnt = 0; done_c = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bi2.RD_BUF) rd_cnt++;
      if (bi2.DONE && done_c == 0) done_c = c;
      tick();
    end
    chk("ws_fast_rd_cycles", rd_cnt, 3);
    chk("ws_fast_done_cycle", done_c, 5);
    chk("ws_fast_rdata", bi2.RDATA, 16'h4242);
    $display("wait states fast: rd cycles=%0d done cycle=%0d", rd_cnt, done_c);

    // Stuck READY: timeout abort, or indefinite stall
    bi0.REQ = 1; bi0.REQ_WR = 0; bi0.REQ_BYTE = 0; bi0.REQ_ADDR = 16'h0077;
    bi0.DIN_BUF = 16'h5555; bi0.READY_BUF = 0;
    tick(); bi0.REQ = 0;
`ifdef BUS_TIMEOUT_EN
    rd_cnt = 0; done_c = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bi0.RD_BUF) rd_cnt++;
      if (bi0.DONE && done_c == 0) begin
        done_c = c;
        chk("to_err", bi0.ERR, 1);
        chk("to_rdata", bi0.RDATA, 16'hFFFF);
        chk("to_strb", {bi0.RD_BUF, bi0.WR_BUF}, 0);
      end
      tick();
    end
    chk("to_rd_cycles", rd_cnt, 8);
    chk("to_done_cycle", done_c, 10);
    $display("timeout: rd cycles=%0d done cycle=%0d", rd_cnt, done_c);
`else
    done_n = 0;
    for (int c = 1; c <= 100; c++) begin
      if (bi0.DONE) done_n++;
      tick();
    end
    chk("stall_no_done", done_n, 0);
    chk("stall_rd", bi0.RD_BUF, 1);
    chk("stall_err", bi0.ERR, 0);
    RESET = 1;
    tick();
    RESET = 0;
    chk("stall_rst_rd", bi0.RD_BUF, 0);
    $display("stall: no done in 100 cycles, aborted by reset");
`endif
    tick();

    // Reset during STROBE of a write
    bi0.REQ = 1; bi0.REQ_WR = 1; bi0.REQ_BYTE = 0; bi0.REQ_ADDR = 16'h0080;
    bi0.REQ_WDATA = 16'hABCD; bi0.READY_BUF = 0;
    tick(); bi0.REQ = 0;
    tick();
    chk("rstw_strobe_wr", bi0.WR_BUF, 2'b11);
    tick();
    RESET = 1;
    tick();
    chk("rstw_wr",   bi0.WR_BUF, 0);
    chk("rstw_rdy",  bi0.REQ_RDY, 1);
    chk("rstw_done", bi0.DONE, 0);
    chk("rstw_addr", bi0.ADDR_BUF, 0);
    chk("rstw_rdata", bi0.RDATA, 0);
    RESET = 0; bi0.READY_BUF = 1;
    done_n = 0;
    for (int c = 0; c < 5; c++) begin
      if (bi0.DONE) done_n++;
      tick();
    end
    chk("rstw_no_done", done_n, 0);
    $display("reset mid-write: wr=%b rdy=%0d", bi0.WR_BUF, bi0.REQ_RDY);

    // Recovery access after the abort
    bi0.REQ = 1; bi0.REQ_WR = 0; bi0.REQ_BYTE = 0; bi0.REQ_ADDR = 16'h0070;
    bi0.DIN_BUF = 16'h0F0F;
    tick(); bi0.REQ = 0;
    chk("rec_setup_addr", bi0.ADDR_BUF, 16'h0070);
    tick();
    chk("rec_rd", bi0.RD_BUF, 1);
    tick();
    chk("rec_done", bi0.DONE, 1);
    chk("rec_err", bi0.ERR, 0);
    chk("rec_rdata", bi0.RDATA, 16'h0F0F);
    tick();
    $display("recovery read: rdata=%h", bi0.RDATA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
